// File: rtl/counter_mod.sv
// counter_mod: up/down counter with an enable prescaler, wrap or saturate at
//   the 0 / term_val boundaries, a one-cycle terminal-count pulse and a sticky
//   boundary flag.
// Ports: clk, reset (async, active-low), cnt_ena, up_dn, clear, load,
//   load_val, term_val, ovf_clr in; count, tc, ovf out (all registered).
// Latency: every input takes effect on the next rising clk edge. No backpressure.
module counter_mod #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_ena,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The prescaler only needs to hold 0..PRESCALE-1; keep it one bit wide
  // when PRESCALE is 1 so the compare below stays trivially true.
  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             tc_q,    tc_d;
  logic             ovf_q,   ovf_d;
  logic             step;
  logic             at_bound;

  always_comb begin
    count_d  = count_q;
    pre_d    = pre_q;
    step     = 1'b0;
    at_bound = 1'b0;

    if (clear) begin
      count_d = '0;
      pre_d   = '0;
    end else if (load) begin
      count_d = load_val;
      pre_d   = '0;
    end else if (cnt_ena) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end

      if (step) begin
        if (up_dn) begin
          // ">=" so a count left above term_val by load or a term_val
          // change is treated as having reached the boundary.
          if (count_q >= term_val) begin
            at_bound = 1'b1;
            count_d  = SATURATE ? count_q : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            at_bound = 1'b1;
            count_d  = SATURATE ? '0 : term_val;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end

    tc_d = at_bound;
    // A boundary event on the same edge as ovf_clr keeps the flag set.
    if (at_bound) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
